ppe_rr_sched: RTL and testbench

- Round-robin grant scheduler that shares one downstream resource (an output/bus port) between N requesters, using a programmable-priority-encoder pick.
- Grants are held for a burst, terminated by a done handshake, request drop or hold timeout.
- The priority pointer advances past the last grantee, giving starvation-free fairness.
- Sits in front of the hierarchical PPE datapath as its sequencing/ownership controller.

---
 rtl/ppe_rr_sched_pkg.sv | 20 ++
 rtl/ppe_rr_sched_pick.sv | 34 +++
 rtl/ppe_rr_sched.sv | 158 +++++++++++++++
 tb/tb_ppe_rr_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package ppe_rr_sched_pkg;

  // Scheduler FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  // Ceiling log2 used to sanity-check index and counter widths at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage : ppe_rr_sched_pkg

// File: rtl/ppe_rr_sched_pick.sv
// Cyclic priority pick: first set bit of req scanning base, base+1, ... N-1, 0, ...
// Ports:
//   req   - request vector
//   base  - highest-priority index (must be < N)
//   idx   - chosen index (0 when nothing found)
//   found - at least one request set
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG_N = 3
) (
  input  logic [N-1:0]     req,
  input  logic [LOG_N-1:0] base,
  output logic [LOG_N-1:0] idx,
  output logic             found
);

  localparam int unsigned N2 = 2 * N;

  logic [N2-1:0] masked;

  // The upper copy of req covers the wrap-around; masking below base leaves the
  // lowest remaining set bit as the cyclic winner.
  always_comb begin
    masked = {req, req} & ~((N2'(1) << base) - N2'(1));
    found  = |req;
    idx    = '0;
    for (int i = int'(N2) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        idx = (i >= int'(N)) ? LOG_N'(i - int'(N)) : LOG_N'(i);
      end
    end
  end

endmodule : rr_pick

// File: rtl/ppe_rr_sched.sv
// Round-robin scheduler granting one shared resource to one of N requesters.
// A grant lasts until the grantee signals done, drops its request, or the hold
// limit expires; the priority pointer then moves past the grantee.
// Ports:
//   clk, rst_n - clock (rising edge), async active-low reset
//   en         - allow new grants (active grant unaffected)
//   req        - per-requester request level
//   done       - per-requester end-of-burst pulse (grantee bit only)
//   gnt        - one-hot grant
//   gnt_id     - index of current grantee
//   gnt_valid  - grant active
//   timeout    - one-cycle pulse when the hold limit alone released the grant
//   ptr        - current highest-priority index
module ppe_rr_sched
  import ppe_rr_sched_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned LOG_N    = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [LOG_N-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [LOG_N-1:0] ptr
);

  // Reject configurations whose index or counter cannot hold its range.
  if (N < 2 || LOG_N < clog2(N) || MAX_HOLD < 1 || HOLD_W < 1 ||
      HOLD_W < clog2(MAX_HOLD)) begin : g_cfg_err
    $error("ppe_rr_sched: invalid N/LOG_N/MAX_HOLD/HOLD_W combination");
  end

  sched_state_e      state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [LOG_N-1:0]  gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [LOG_N-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [LOG_N-1:0]  rel_ptr;
  logic [LOG_N-1:0]  ptr_eval;
  logic [LOG_N-1:0]  pick_idx;
  logic              pick_found;
  logic              done_g, req_g, hold_hit, rel;

  // Release conditions for the current grantee.
  always_comb begin
    done_g   = done[gnt_id_q];
    req_g    = req[gnt_id_q];
    hold_hit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    rel      = done_g | ~req_g | hold_hit;
    rel_ptr  = (gnt_id_q == LOG_N'(N - 1)) ? '0 : gnt_id_q + LOG_N'(1);
    // On a release cycle the pick already starts past the releasing grantee.
    ptr_eval = (state_q == ST_GRANT) ? rel_ptr : ptr_q;
  end

  rr_pick #(
    .N     (N),
    .LOG_N (LOG_N)
  ) u_pick (
    .req   (req),
    .base  (ptr_eval),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (en && pick_found) begin
          state_d     = ST_GRANT;
          gnt_d       = N'(1) << pick_idx;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
        end
      end

      ST_GRANT: begin
        if (!rel) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          ptr_d      = rel_ptr;
          // Done or drop on the same cycle masks the timeout indication.
          timeout_d  = hold_hit & ~done_g & req_g;
          hold_cnt_d = '0;
          if (en && pick_found) begin
            gnt_d       = N'(1) << pick_idx;
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign ptr       = ptr_q;

endmodule : ppe_rr_sched

// File: tb/tb_ppe_rr_sched.sv
// Directed testbench for ppe_rr_sched with default parameters (N=8, MAX_HOLD=16).
// Observed vector is {gnt, gnt_id, gnt_valid, timeout, ptr}.
module tb_ppe_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [2:0] ptr;

  int n_pass;
  int n_total;

  logic [15:0] obs;
  assign obs = {gnt, gnt_id, gnt_valid, timeout, ptr};

  ppe_rr_sched #(
    .N        (8),
    .LOG_N    (3),
    .MAX_HOLD (16),
    .HOLD_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) @(posedge clk);
    #1;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd0};
    n_total++;
    if (obs !== exp) $display("FAIL reset_state: got {gnt,id,v,to,ptr}=%h want %h", obs, exp);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    en  = 1'b1;
    req = 8'h04;
    step();
    exp = {8'h04, 3'd2, 1'b1, 1'b0, 3'd0};
    n_total++;
    if (obs !== exp) $display("FAIL basic_grant: got %h want %h", obs, exp);
    else n_pass++;
    done = 8'h04;
    req  = 8'h00;
    step();
    done = 8'h00;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd3};
    n_total++;
    if (obs !== exp) $display("FAIL basic_done_release: got %h want %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int e, nx;
    req = 8'hFF;
    step();
    exp = {8'h08, 3'd3, 1'b1, 1'b0, 3'd3};
    n_total++;
    if (obs !== exp) $display("FAIL b2b_first: got %h want %h", obs, exp);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      e  = (3 + i) % 8;
      nx = (e + 1) % 8;
      step();
      exp = {8'(1) << e, 3'(e), 1'b1, 1'b0, 3'(e)};
      n_total++;
      if (obs !== exp) $display("FAIL b2b_hold_%0d: got %h want %h", i, obs, exp);
      else n_pass++;
      done = 8'(1) << e;
      step();
      done = 8'h00;
      exp = {8'(1) << nx, 3'(nx), 1'b1, 1'b0, 3'(nx)};
      n_total++;
      if (obs !== exp) $display("FAIL b2b_next_%0d: got %h want %h", i, obs, exp);
      else n_pass++;
    end
    req = 8'h00;
    step();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd4};
    n_total++;
    if (obs !== exp) $display("FAIL b2b_drain: got %h want %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [15:0] exp;
    req = 8'h20;
    step();
    exp = {8'h20, 3'd5, 1'b1, 1'b0, 3'd4};
    n_total++;
    if (obs !== exp) $display("FAIL hold_start: got %h want %h", obs, exp);
    else n_pass++;
    for (int i = 1; i < 16; i++) begin
      step();
      n_total++;
      if (obs !== exp) $display("FAIL hold_cycle_%0d: got %h want %h", i, obs, exp);
      else n_pass++;
    end
    step();
    exp = {8'h20, 3'd5, 1'b1, 1'b1, 3'd6};
    n_total++;
    if (obs !== exp) $display("FAIL timeout_pulse: got %h want %h", obs, exp);
    else n_pass++;
    step();
    exp = {8'h20, 3'd5, 1'b1, 1'b0, 3'd6};
    n_total++;
    if (obs !== exp) $display("FAIL timeout_one_cycle: got %h want %h", obs, exp);
    else n_pass++;
    req = 8'h00;
    step();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd6};
    n_total++;
    if (obs !== exp) $display("FAIL timeout_drain: got %h want %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_ignore_done();
    logic [15:0] exp;
    req = 8'h02;
    step();
    exp = {8'h02, 3'd1, 1'b1, 1'b0, 3'd6};
    n_total++;
    if (obs !== exp) $display("FAIL wrap_grant: got %h want %h", obs, exp);
    else n_pass++;
    done = 8'h11;
    step();
    done = 8'h00;
    n_total++;
    if (obs !== exp) $display("FAIL foreign_done: got %h want %h", obs, exp);
    else n_pass++;
    req = 8'h00;
    step();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd2};
    n_total++;
    if (obs !== exp) $display("FAIL drop_release: got %h want %h", obs, exp);
    else n_pass++;
    done = 8'hFF;
    step();
    done = 8'h00;
    n_total++;
    if (obs !== exp) $display("FAIL idle_done: got %h want %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    req = 8'h08;
    step();
    exp = {8'h08, 3'd3, 1'b1, 1'b0, 3'd2};
    n_total++;
    if (obs !== exp) $display("FAIL pre_reset_grant: got %h want %h", obs, exp);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd0};
    n_total++;
    if (obs !== exp) $display("FAIL async_reset: got %h want %h", obs, exp);
    else n_pass++;
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_total++;
    if (obs !== exp) $display("FAIL post_reset_idle: got %h want %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_enable();
    logic [15:0] exp;
    en  = 1'b0;
    req = 8'h81;
    step();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd0};
    n_total++;
    if (obs !== exp) $display("FAIL en_low_no_grant: got %h want %h", obs, exp);
    else n_pass++;
    en = 1'b1;
    step();
    exp = {8'h01, 3'd0, 1'b1, 1'b0, 3'd0};
    n_total++;
    if (obs !== exp) $display("FAIL en_grant0: got %h want %h", obs, exp);
    else n_pass++;
    en = 1'b0;
    step();
    n_total++;
    if (obs !== exp) $display("FAIL en_low_hold: got %h want %h", obs, exp);
    else n_pass++;
    done = 8'h01;
    step();
    done = 8'h00;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd1};
    n_total++;
    if (obs !== exp) $display("FAIL en_low_release: got %h want %h", obs, exp);
    else n_pass++;
    step();
    n_total++;
    if (obs !== exp) $display("FAIL en_low_stay_idle: got %h want %h", obs, exp);
    else n_pass++;
    req = 8'h00;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    req     = '0;
    done    = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_ignore_done();
    test_async_reset();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ppe_rr_sched
